// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR MAC sequencer: default widths,
// the FSM state encoding and the output saturation helper.
package fir_pkg;

  localparam int TAPS   = 6;
  localparam int BITS_I = 3;
  localparam int BITS_A = 16;
  localparam int BITS_X = 16;
  localparam int BITS_Y = 40;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  // Clamp an accumulator value to the signed range of a bits_x-wide sample.
  function automatic logic signed [BITS_Y-1:0] sat_clamp(
    input logic signed [BITS_Y-1:0] value,
    input int                       bits_x
  );
    logic signed [BITS_Y-1:0] hi;
    logic signed [BITS_Y-1:0] lo;
    hi = (BITS_Y'(1) << (bits_x - 1)) - BITS_Y'(1);
    lo = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register. A load pushes din into slot 0 and moves
// every older sample one slot deeper; rd_idx selects one slot for the MAC.
// Indices at or beyond TAPS read as zero.
module fir_delay_line #(
  parameter int TAPS   = fir_pkg::TAPS,
  parameter int BITS_X = fir_pkg::BITS_X,
  parameter int IDX_W  = fir_pkg::BITS_I
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BITS_X-1:0] din,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BITS_X-1:0] dout
);

  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(TAPS);

  logic [BITS_X-1:0] taps [TAPS];

  // Shift a new sample in on load; reset clears the whole history.
  // NOTE: this array is reset explicitly because filter outputs after reset
  // must see zero history; a plain storage RAM would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (load) begin
      taps[0] <= din;
      for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = (rd_idx < IDX_LIMIT) ? taps[rd_idx] : '0;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed serial FIR controller. Accepts one sample per handshake,
// then walks coef_addr 1..TAPS over an external combinational ROM,
// accumulating coef * x[TAPS-coef_addr], and emits one registered result.
// Optional build macro FIR_SAT_EN clamps y_out to the sample range.
module fir_mac_sequencer #(
  parameter int TAPS   = fir_pkg::TAPS,
  parameter int BITS_I = fir_pkg::BITS_I,
  parameter int BITS_A = fir_pkg::BITS_A,
  parameter int BITS_X = fir_pkg::BITS_X,
  parameter int BITS_Y = fir_pkg::BITS_Y
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_X-1:0] x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [BITS_I-1:0] coef_addr,
  input  logic [BITS_A-1:0] coef,
  output logic [BITS_Y-1:0] y_out,
  output logic              y_valid,
  output logic              busy
);

  import fir_pkg::*;

  localparam int               PW         = BITS_X + BITS_A;
  localparam logic [BITS_I-1:0] FIRST_ADDR = BITS_I'(1);
  localparam logic [BITS_I-1:0] LAST_ADDR  = BITS_I'(TAPS);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   last;

  logic [BITS_I-1:0]        tap_idx;
  logic [BITS_X-1:0]        tap_raw;
  logic signed [BITS_X-1:0] tap_s;
  logic signed [BITS_A-1:0] coef_s;
  logic signed [PW-1:0]     prod;
  logic signed [BITS_Y-1:0] prod_ext;
  logic signed [BITS_Y-1:0] acc;
  logic signed [BITS_Y-1:0] acc_next;
  logic signed [BITS_Y-1:0] result;

  // coef_addr 1 reads the oldest sample (slot TAPS-1), coef_addr TAPS the newest.
  assign tap_idx = LAST_ADDR - coef_addr;

  fir_delay_line #(
    .TAPS   (TAPS),
    .BITS_X (BITS_X),
    .IDX_W  (BITS_I)
  ) u_delay_line (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .din    (x_in),
    .rd_idx (tap_idx),
    .dout   (tap_raw)
  );

  assign tap_s    = tap_raw;
  assign coef_s   = coef;
  assign prod     = PW'(coef_s) * PW'(tap_s);
  assign prod_ext = {{(BITS_Y-PW){prod[PW-1]}}, prod};
  assign acc_next = acc + prod_ext;

`ifdef FIR_SAT_EN
  assign result = sat_clamp(acc_next, BITS_X);
`else
  assign result = acc_next;
`endif

  assign x_ready = (state == ST_IDLE);
  assign busy    = (state == ST_MAC);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode: accept in IDLE, finish after the last tap in MAC.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (x_valid) begin
          accept     = 1'b1;
          next_state = ST_MAC;
        end
      end
      ST_MAC: begin
        if (coef_addr == LAST_ADDR) begin
          last       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: ROM address stepping, accumulation and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_addr <= '0;
      acc       <= '0;
      y_out     <= '0;
      y_valid   <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (accept) begin
        acc       <= '0;
        coef_addr <= FIRST_ADDR;
      end else if (state == ST_MAC) begin
        acc <= acc_next;
        if (last) begin
          y_out     <= result;
          y_valid   <= 1'b1;
          coef_addr <= '0;
        end else begin
          coef_addr <= coef_addr + FIRST_ADDR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a six-entry coefficient ROM
// (address 1..6 = 0,1,7,7,1,0). Expected outputs are hand-computed.
// Honours FIR_SAT_EN when the same macro is defined for the build.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_in;
  logic        x_valid;
  logic        x_ready;
  logic [2:0]  coef_addr;
  logic [15:0] coef;
  logic [39:0] y_out;
  logic        y_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .coef_addr (coef_addr),
    .coef      (coef),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Combinational coefficient ROM.
  always_comb begin
    coef = 16'd0;
    case (coef_addr)
      3'd2:    coef = 16'd1;
      3'd3:    coef = 16'd7;
      3'd4:    coef = 16'd7;
      3'd5:    coef = 16'd1;
      default: coef = 16'd0;
    endcase
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint y_s();
    return longint'($signed(y_out));
  endfunction

  // Drive one sample, follow the ROM walk and check the resulting output.
  task automatic send(input longint v, input longint exp_y, input string tag);
    int waits;
    @(negedge clk);
    check({tag, "_yvalid_low"}, y_valid, 0);
    x_in    = v[15:0];
    x_valid = 1'b1;
    waits   = 0;
    while (!x_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_ready"}, x_ready, 1);
    @(negedge clk);
    x_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("%s_addr%0d", tag, k), coef_addr, k);
      @(negedge clk);
    end
    check({tag, "_yvalid"}, y_valid, 1);
    check({tag, "_yout"}, y_s(), exp_y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  longint imp_exp  [6] = '{0, 1, 7, 7, 1, 0};
  longint step_exp [6] = '{0, 100, 800, 1500, 1600, 1600};
  longint neg_exp  [6] = '{0, -3, -21, -21, -3, 0};
`ifdef FIR_SAT_EN
  longint sat_exp  [6] = '{0, 32767, 32767, 32767, 32767, 32767};
`else
  longint sat_exp  [6] = '{0, 32767, 262136, 491505, 524272, 524272};
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int pulses;
    int low_cnt;
    int run;
    int max_run;
    logic prev_yv;
    int waits;

    rst     = 1'b1;
    x_in    = '0;
    x_valid = 1'b0;
    do_reset();

    // Reset state.
    check("rst_ready", x_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", coef_addr, 0);
    check("rst_yout", y_s(), 0);
    check("rst_yvalid", y_valid, 0);

    // Impulse.
    for (int i = 0; i < 6; i++)
      send((i == 0) ? 1 : 0, imp_exp[i], $sformatf("imp%0d", i));

    // Step.
    for (int i = 0; i < 6; i++)
      send(100, step_exp[i], $sformatf("step%0d", i));

    // Reset in the middle of a MAC run.
    @(negedge clk);
    x_in    = 16'd5;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    waits   = 0;
    while (coef_addr != 3'd3 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("mid_addr3", coef_addr, 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ready", x_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_yvalid", y_valid, 0);
    check("mid_yout", y_s(), 0);
    check("mid_addr", coef_addr, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      send((i == 0) ? 1 : 0, imp_exp[i], $sformatf("postrst%0d", i));

    // Negative impulse (history is all zero but the oldest slot).
    for (int i = 0; i < 6; i++)
      send((i == 0) ? -3 : 0, neg_exp[i], $sformatf("neg%0d", i));

    // Continuous x_valid: one sample per 7 cycles, 6-cycle ready gaps.
    @(negedge clk);
    x_in    = 16'd0;
    x_valid = 1'b1;
    accepts = 0;
    pulses  = 0;
    low_cnt = 0;
    run     = 0;
    max_run = 0;
    prev_yv = 1'b0;
    for (int n = 0; n < 21; n++) begin
      if (x_ready) begin
        accepts++;
        run = 0;
      end else begin
        low_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end
      if (y_valid) begin
        pulses++;
        if (prev_yv) check("hs_yvalid_double", 1, 0);
      end
      prev_yv = y_valid;
      @(negedge clk);
    end
    check("hs_final_yvalid", y_valid, 1);
    x_valid = 1'b0;
    check("hs_accepts", accepts, 3);
    check("hs_pulses", pulses, 2);
    check("hs_ready_low", low_cnt, 18);
    check("hs_max_gap", max_run, 6);

    // Large step: saturates only in the FIR_SAT_EN build.
    do_reset();
    check("sat_rst_yout", y_s(), 0);
    for (int i = 0; i < 6; i++)
      send(32767, sat_exp[i], $sformatf("sat%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed controller for a serial FIR filter. It accepts one input sample per handshake and shifts it into a TAPS-deep delay line. It then steps the coefficient ROM address from 1 to TAPS, accumulating coefficient × delayed-sample products, and emits one filtered output per sample. It sits between the sample source and the downstream consumer and drives the combinational coefficient ROM (address 1 = a5 … address 6 = a0).

Parameters:
TAPS, 6, number of filter taps; ROM addresses 1..TAPS used, address 0 unused.
BITS_I, 3, coefficient ROM address width; must satisfy 2^BITS_I > TAPS.
BITS_A, 16, signed coefficient width.
BITS_X, 16, signed input sample width.
BITS_Y, 40, signed accumulator/output width; must be ≥ BITS_X+BITS_A+ceil(log2(TAPS)).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
x_in  input  BITS_X  signed input sample.
x_valid  input  1  x_in valid.
x_ready  output  1  block can accept a sample.
coef_addr  output  BITS_I  address to coefficient ROM.
coef  input  BITS_A  signed coefficient returned combinationally by ROM for coef_addr.
y_out  output  BITS_Y  signed filtered output, registered.
y_valid  output  1  one-cycle pulse: y_out holds a new result.
busy  output  1  high while in MAC state.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, delay line x[0..TAPS-1]=0, acc=0, coef_addr=0, y_out=0, y_valid=0. Reset mid-MAC aborts the computation; no y_valid is produced for the aborted sample.
- States: IDLE, MAC.
- IDLE: x_ready=1, busy=0, coef_addr=0. On x_valid&x_ready: x[k]<=x[k-1] for k=TAPS-1..1, x[0]<=x_in, acc<=0, coef_addr<=1, go to MAC.
- MAC: x_ready=0, busy=1. Each edge: acc<=acc+coef*x[TAPS-coef_addr], with the product signed (BITS_X+BITS_A) and sign-extended to BITS_Y.
  - If coef_addr<TAPS: coef_addr increments.
  - If coef_addr==TAPS: y_out<=acc+product, y_valid<=1, coef_addr<=0, go to IDLE.
- x_valid during MAC is ignored (not consumed). The source must hold it until x_ready.
- y_valid is high for exactly one cycle: the first IDLE cycle after MAC. A new sample can be accepted in that same cycle. Throughput is one sample per TAPS+1 cycles.
- Latency: acceptance edge E0 → y_out/y_valid valid after edge E_TAPS (6 cycles for default).
- y_out holds its last value until the next result or reset.
- Accumulator arithmetic is two's complement with wrap at BITS_Y. Overflow is impossible when the BITS_Y constraint holds.
- The delay line is never cleared except by reset. The first TAPS-1 outputs after reset therefore include zero history.

Optional Feature:
Macro FIR_SAT_EN.
- Defined: the final value written to y_out is clamped to [-2^(BITS_X-1), 2^(BITS_X-1)-1], sign-extended in BITS_Y.
- Undefined: y_out is the full unclamped accumulator.
- Timing and handshakes are identical in both builds.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding constants ST_IDLE/ST_MAC;
  - default widths BITS_I/BITS_A/BITS_X/BITS_Y and TAPS;
  - the saturation limits function.
- One natural sub-module, fir_delay_line (TAPS×BITS_X shift register with load enable and indexed read), instantiated by fir_mac_sequencer.
- The coefficient ROM stays external and is connected via coef_addr/coef.

Test Plan:
- Impulse: after reset, feed x=1 then five x=0 (coefs a5..a0 = 0,1,7,7,1,0) → y_out sequence 0,1,7,7,1,0 and coef_addr stepping 1..6 per sample.
- Step: feed x=100 six times → final y_out=1600; earlier outputs 0,100,800,1500,1600,1600.
- Negative impulse: x=-3 then zeros → y_out 0,-3,-21,-21,-3,0, checking sign extension.
- Handshake: hold x_valid=1 continuously → x_ready low for 6 MAC cycles; exactly one sample consumed per 7 cycles; y_valid pulses one cycle each.
- Reset mid-MAC: assert rst at coef_addr=3 → next cycle state IDLE, y_valid=0, y_out=0, delay line zero. A subsequent x=1 impulse gives y_out=0 first.
- FIR_SAT_EN build: feed x=32767 six times → y_out=32767, where an unsaturated build gives 524272.
